// File: rtl/io_bus_pkg.sv
// rtl/io_bus_pkg.sv - shared state encoding, chip-select and page constants for the I/O bus arbiter
package io_bus_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        STROBE  = 2'd1,
        CAPTURE = 2'd2
    } io_state_t;

    localparam logic [7:0]  PAGE_COMM      = 8'h99;
    localparam logic [7:0]  PAGE_AUX       = 8'h69;
    localparam logic [15:0] RDATA_UNMAPPED = 16'h0000;

    localparam logic [7:0]  CS_COMM = 8'b0000_0100;
    localparam logic [7:0]  CS_AUX  = 8'b0000_1000;

endpackage

// File: rtl/io_bus_arbiter_if.sv
// rtl/io_bus_arbiter_if.sv - one master's request/acknowledge port onto the I/O bus
interface io_bus_arbiter_if;
    logic        req;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        ack;
    logic [15:0] rdata;

    modport master (output req, we, addr, wdata, input ack, rdata);
    modport slave  (input req, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/io_page_decoder.sv
// rtl/io_page_decoder.sv - address page to one-hot chip-select decoder
module io_page_decoder
    import io_bus_pkg::*;
#(
    parameter logic [7:0] COMM_PAGE = PAGE_COMM,
    parameter logic [7:0] AUX_PAGE  = PAGE_AUX
) (
    input  logic [7:0] page,
    output logic [7:0] cs,
    output logic       mapped
);

    // Pages without a peripheral select nothing and report unmapped
    always_comb begin
        cs     = 8'h00;
        mapped = 1'b0;
        if (page == COMM_PAGE) begin
            cs     = CS_COMM;
            mapped = 1'b1;
        end else if (page == AUX_PAGE) begin
            cs     = CS_AUX;
            mapped = 1'b1;
        end
    end

endmodule

// File: rtl/io_bus_arbiter.sv
// rtl/io_bus_arbiter.sv - two-master round-robin I/O bus arbiter; optional IO_ARB_TIMEOUT_EN adds bus_timeout
module io_bus_arbiter
    import io_bus_pkg::*;
#(
    parameter logic [7:0]  COMM_PAGE     = PAGE_COMM,
    parameter logic [7:0]  AUX_PAGE      = PAGE_AUX,
    parameter logic [15:0] UNMAPPED_DATA = RDATA_UNMAPPED
) (
    input  logic            clk,
    input  logic            rst,
    io_bus_arbiter_if.slave m0,
    io_bus_arbiter_if.slave m1,
    output logic            bus_rd,
    output logic            bus_wr,
    output logic [15:0]     bus_addr,
    output logic [15:0]     bus_dout,
    output logic [7:0]      cs,
    input  logic [15:0]     comm_din,
    input  logic [15:0]     aux_din,
    output logic            bus_err
`ifdef IO_ARB_TIMEOUT_EN
    ,
    output logic            bus_timeout
`endif
);

    io_state_t   state;
    logic        last_grant;   // 0 = m0 granted last, 1 = m1 granted last
    logic        winner;       // master owning the transaction in flight
    logic        bus_we;
    logic        mapped_q;

    logic        grant_m1;
    logic        sel_we;
    logic [15:0] sel_addr;
    logic [15:0] sel_wdata;
    logic [7:0]  sel_cs;
    logic        sel_mapped;
    logic [15:0] capture_data;

    // Round-robin pick: on contention the master not granted last wins
    always_comb begin
        grant_m1 = m1.req;
        if (m0.req && m1.req) begin
            grant_m1 = ~last_grant;
        end
        sel_we    = grant_m1 ? m1.we    : m0.we;
        sel_addr  = grant_m1 ? m1.addr  : m0.addr;
        sel_wdata = grant_m1 ? m1.wdata : m0.wdata;
    end

    io_page_decoder #(
        .COMM_PAGE (COMM_PAGE),
        .AUX_PAGE  (AUX_PAGE)
    ) u_decoder (
        .page   (sel_addr[15:8]),
        .cs     (sel_cs),
        .mapped (sel_mapped)
    );

    // Read mux driven by the live chip-select; unmapped reads return a constant, never X
    always_comb begin
        capture_data = UNMAPPED_DATA;
        if (cs == CS_COMM) begin
            capture_data = comm_din;
        end else if (cs == CS_AUX) begin
            capture_data = aux_din;
        end
    end

    // Transaction FSM: strobes, chip-select, acks and read data are all registered
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            winner     <= 1'b0;
            bus_we     <= 1'b0;
            mapped_q   <= 1'b0;
            bus_rd     <= 1'b0;
            bus_wr     <= 1'b0;
            bus_addr   <= 16'h0000;
            bus_dout   <= 16'h0000;
            cs         <= 8'h00;
            bus_err    <= 1'b0;
            m0.ack     <= 1'b0;
            m1.ack     <= 1'b0;
            m0.rdata   <= 16'h0000;
            m1.rdata   <= 16'h0000;
        end else begin
            bus_rd <= 1'b0;
            bus_wr <= 1'b0;
            cs     <= 8'h00;
            m0.ack <= 1'b0;
            m1.ack <= 1'b0;
            case (state)
                IDLE: begin
                    if (m0.req || m1.req) begin
                        winner     <= grant_m1;
                        last_grant <= grant_m1;
                        bus_we     <= sel_we;
                        bus_addr   <= sel_addr;
                        bus_dout   <= sel_wdata;
                        mapped_q   <= sel_mapped;
                        bus_rd     <= sel_mapped & ~sel_we;
                        bus_wr     <= sel_mapped & sel_we;
                        cs         <= sel_cs;
                        state      <= STROBE;
                    end
                end
                STROBE: begin
                    if (!mapped_q) begin
                        bus_err <= 1'b1;
                    end
                    if (winner) begin
                        m1.ack <= 1'b1;
                        if (!bus_we) begin
                            m1.rdata <= capture_data;
                        end
                    end else begin
                        m0.ack <= 1'b1;
                        if (!bus_we) begin
                            m0.rdata <= capture_data;
                        end
                    end
                    state <= CAPTURE;
                end
                CAPTURE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef IO_ARB_TIMEOUT_EN
    logic [7:0] wait_m0;
    logic [7:0] wait_m1;
    logic       busy_m0;
    logic       busy_m1;

    always_comb begin
        busy_m0 = (state != IDLE) && !winner;
        busy_m1 = (state != IDLE) && winner;
    end

    // Per-master starvation counters; saturate and latch bus_timeout at 255
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_m0     <= 8'h00;
            wait_m1     <= 8'h00;
            bus_timeout <= 1'b0;
        end else begin
            if (m0.ack) begin
                wait_m0 <= 8'h00;
            end else if (m0.req && !busy_m0 && wait_m0 != 8'hFF) begin
                wait_m0 <= wait_m0 + 8'd1;
            end
            if (m1.ack) begin
                wait_m1 <= 8'h00;
            end else if (m1.req && !busy_m1 && wait_m1 != 8'hFF) begin
                wait_m1 <= wait_m1 + 8'd1;
            end
            if (wait_m0 == 8'hFF || wait_m1 == 8'hFF) begin
                bus_timeout <= 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_io_bus_arbiter.sv
// tb/tb_io_bus_arbiter.sv - randomized self-checking bench with a transaction-level model
module tb_io_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        bus_rd;
    logic        bus_wr;
    logic [15:0] bus_addr;
    logic [15:0] bus_dout;
    logic [7:0]  cs;
    logic [15:0] comm_din;
    logic [15:0] aux_din;
    logic        bus_err;
`ifdef IO_ARB_TIMEOUT_EN
    logic        bus_timeout;
`endif

    io_bus_arbiter_if m0_if ();
    io_bus_arbiter_if m1_if ();

    io_bus_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .m0       (m0_if),
        .m1       (m1_if),
        .bus_rd   (bus_rd),
        .bus_wr   (bus_wr),
        .bus_addr (bus_addr),
        .bus_dout (bus_dout),
        .cs       (cs),
        .comm_din (comm_din),
        .aux_din  (aux_din),
        .bus_err  (bus_err)
`ifdef IO_ARB_TIMEOUT_EN
        ,
        .bus_timeout (bus_timeout)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Transaction-level model: one transaction occupies the bus for three cycles
    int          t = 0;
    int          n_last = -100;
    int          last_m = 1;
    bit          txn_valid = 0;
    int          txn_m = 0;
    bit          txn_we = 0;
    logic [15:0] txn_addr = 0;
    logic [15:0] exp_addr = 0;
    logic [15:0] exp_dout = 0;
    logic [15:0] exp_rdata [2];
    bit          exp_err = 0;
    bit          ack_now [2];
    bit          prev_strobe = 0;
    int          grant_log [$];

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h at cycle %0d", tag, observed, expected, t);
        end
    endtask

    function automatic logic [7:0] page_cs(input logic [15:0] a);
        if (a[15:8] == 8'h99) return 8'h04;
        if (a[15:8] == 8'h69) return 8'h08;
        return 8'h00;
    endfunction

    task automatic tick();
        bit strobe_now;
        bit mapped;
        if (rst) begin
            txn_valid    = 0;
            n_last       = -100;
            last_m       = 1;
            exp_rdata[0] = 16'h0000;
            exp_rdata[1] = 16'h0000;
            exp_err      = 0;
            exp_addr     = 16'h0000;
            exp_dout     = 16'h0000;
        end else begin
            if (txn_valid && t == n_last + 1) begin
                if (page_cs(txn_addr) == 8'h00) exp_err = 1;
                if (!txn_we) begin
                    case (page_cs(txn_addr))
                        8'h04:   exp_rdata[txn_m] = comm_din;
                        8'h08:   exp_rdata[txn_m] = aux_din;
                        default: exp_rdata[txn_m] = 16'h0000;
                    endcase
                end
            end
            if (t >= n_last + 3 && (m0_if.req || m1_if.req)) begin
                if (m0_if.req && m1_if.req) txn_m = (last_m == 0) ? 1 : 0;
                else                        txn_m = m1_if.req ? 1 : 0;
                last_m    = txn_m;
                txn_valid = 1;
                n_last    = t;
                txn_we    = (txn_m == 1) ? m1_if.we : m0_if.we;
                txn_addr  = (txn_m == 1) ? m1_if.addr : m0_if.addr;
                exp_addr  = txn_addr;
                exp_dout  = (txn_m == 1) ? m1_if.wdata : m0_if.wdata;
            end
        end
        @(posedge clk);
        t++;
        #1;
        strobe_now = txn_valid && (t == n_last + 1);
        mapped     = page_cs(txn_addr) != 8'h00;
        ack_now[0] = txn_valid && (t == n_last + 2) && (txn_m == 0);
        ack_now[1] = txn_valid && (t == n_last + 2) && (txn_m == 1);
        chk("bus_rd",   32'(bus_rd),   32'(strobe_now && mapped && !txn_we));
        chk("bus_wr",   32'(bus_wr),   32'(strobe_now && mapped && txn_we));
        chk("cs",       32'(cs),       32'(strobe_now ? page_cs(txn_addr) : 8'h00));
        chk("bus_addr", 32'(bus_addr), 32'(exp_addr));
        chk("bus_dout", 32'(bus_dout), 32'(exp_dout));
        chk("m0_ack",   32'(m0_if.ack), 32'(ack_now[0]));
        chk("m1_ack",   32'(m1_if.ack), 32'(ack_now[1]));
        chk("m0_rdata", 32'(m0_if.rdata), 32'(exp_rdata[0]));
        chk("m1_rdata", 32'(m1_if.rdata), 32'(exp_rdata[1]));
        chk("bus_err",  32'(bus_err),  32'(exp_err));
        chk("rd_wr_overlap", 32'(bus_rd && bus_wr), 32'd0);
        chk("strobe_b2b", 32'(prev_strobe && (bus_rd || bus_wr)), 32'd0);
        prev_strobe = bus_rd || bus_wr;
        if (m0_if.ack) grant_log.push_back(0);
        if (m1_if.ack) grant_log.push_back(1);
    endtask

    task automatic set_master(input int m, input bit req, input bit we,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (m == 0) begin
            m0_if.req = req; m0_if.we = we; m0_if.addr = addr; m0_if.wdata = wdata;
        end else begin
            m1_if.req = req; m1_if.we = we; m1_if.addr = addr; m1_if.wdata = wdata;
        end
    endtask

    task automatic do_txn(input int m, input bit we, input logic [15:0] addr, input logic [15:0] wdata);
        set_master(m, 1'b1, we, addr, wdata);
        for (int i = 0; i < 8; i++) begin
            tick();
            if (ack_now[m]) break;
        end
        set_master(m, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] rand_addr();
        logic [7:0] lo;
        lo = 8'($urandom);
        case ($urandom_range(0, 3))
            0:       return {8'h99, lo};
            1:       return {8'h69, lo};
            2:       return {8'h12, lo};
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        rst      = 1'b1;
        comm_din = 16'h0000;
        aux_din  = 16'h0000;
        set_master(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_master(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        exp_rdata[0] = 16'h0000;
        exp_rdata[1] = 16'h0000;

        do_reset();
        tick();

        do_txn(0, 1'b1, 16'h9904, 16'hA5A5);
        tick();
        aux_din  = 16'h1234;
        comm_din = 16'hBEEF;
        do_txn(1, 1'b0, 16'h6902, 16'h0000);
        tick();
        do_txn(0, 1'b0, 16'h9910, 16'h0000);
        do_txn(0, 1'b0, 16'h1200, 16'h0000);
        repeat (4) tick();
        chk("bus_err_sticky", 32'(bus_err), 32'd1);

        do_reset();
        grant_log.delete();
        set_master(0, 1'b1, 1'b1, 16'h9900, 16'h1111);
        set_master(1, 1'b1, 1'b0, 16'h6900, 16'h0000);
        repeat (12) tick();
        set_master(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        set_master(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        repeat (3) tick();
        chk("grant_count", 32'(grant_log.size() >= 4), 32'd1);
        if (grant_log.size() >= 4) begin
            chk("grant0", 32'(grant_log[0]), 32'd0);
            chk("grant1", 32'(grant_log[1]), 32'd1);
            chk("grant2", 32'(grant_log[2]), 32'd0);
            chk("grant3", 32'(grant_log[3]), 32'd1);
        end

        set_master(0, 1'b1, 1'b1, 16'h9920, 16'h5A5A);
        tick();
        rst = 1'b1;
        set_master(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        tick();
        rst = 1'b0;
        repeat (5) tick();

        for (int c = 0; c < 400; c++) begin
            comm_din = 16'($urandom);
            aux_din  = 16'($urandom);
            for (int m = 0; m < 2; m++) begin
                bit cur_req;
                cur_req = (m == 0) ? m0_if.req : m1_if.req;
                if (ack_now[m] || !cur_req) begin
                    if ($urandom_range(0, 99) < (ack_now[m] ? 50 : 35))
                        set_master(m, 1'b1, 1'($urandom), rand_addr(), 16'($urandom));
                    else
                        set_master(m, 1'b0, 1'b0, 16'h0000, 16'h0000);
                end
            end
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
